// File: rtl/as1802_bus_pkg.sv
// as1802_bus_pkg
//  Shared definitions for the as1802 bus responder slice: bus-cycle FSM
//  states, I/O port packing constants and a port-number to strobe helper.
//  Optional feature macro used by the top: AS1802_BUS_WP_EN (write protect).
package as1802_bus_pkg;

  // Bus-cycle tracking states: IDLE (no cycle), HI (high address byte on
  // the bus), LO (low byte / data phase), WR (write strobe seen this cycle).
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2,
    WR   = 2'd3
  } bus_state_t;

  localparam int unsigned IO_PORTS = 7;
  localparam int unsigned PORT_W   = 8;
  localparam int unsigned IO_BUS_W = IO_PORTS * PORT_W;

  // Port numbers run 1..7; port k owns strobe bit k-1. Port 0 is memory.
  function automatic logic [IO_PORTS-1:0] port_onehot(input logic [2:0] port);
    logic [IO_PORTS-1:0] oh;
    oh = '0;
    if (port != 3'd0) oh[port - 3'd1] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/as1802_bus_mem.sv
// as1802_bus_mem
//  On-chip byte memory behind the as1802 bus responder. One synchronous
//  write port shared by the CPU and the host loader, asynchronous read.
//  Contents are never reset.
// Ports:
//  clk       in   1    clock
//  rd_addr   in   AW   read address (combinational read)
//  rd_data   out  8    read data
//  cpu_we    in   1    CPU write enable (already qualified by the top)
//  cpu_addr  in   AW   CPU write address
//  cpu_data  in   8    CPU write data
//  ld_we     in   1    loader write enable; takes the write port when high
//  ld_addr   in   AW   loader address
//  ld_data   in   8    loader data
module as1802_bus_mem #(
  parameter int unsigned AW = 9
) (
  input  logic          clk,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_data,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [7:0]    ld_data
);

  logic [7:0]    mem_reg [2**AW];
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;

  // Loader owns the single write port whenever it is active, so a loader
  // write always beats a CPU write landing on the same edge.
  always_comb begin
    wr_en   = cpu_we | ld_we;
    wr_addr = cpu_addr;
    wr_data = cpu_data;
    if (ld_we) begin
      wr_addr = ld_addr;
      wr_data = ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_reg[wr_addr] <= wr_data;
  end

  assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/as1802_bus_responder.sv
// as1802_bus_responder
//  Memory / I-O target on the as1802 multiplexed bus. Latches the high
//  address byte on TPA, serves reads combinationally from on-chip memory or
//  one of 7 input ports, commits writes on MWR to memory or one of 7 output
//  latches, and flags protocol misuse.
//  Optional feature: define AS1802_BUS_WP_EN to drop CPU memory writes below
//  WP_LIMIT and raise the sticky wp_fault flag.
// Ports:
//  clk, rst_n            clock; asynchronous active-low reset
//  address, tpa          multiplexed address bus and high-byte strobe
//  mrd, mwr              active-low cycle/read and write strobes
//  n                     I/O select, 0 = memory cycle
//  wr_data / rd_data     CPU data out / data in
//  io_in / io_out        7 byte ports, port k at [8k-1 -: 8]
//  io_out_strb           one-cycle pulse per written output port
//  ld_we/ld_addr/ld_data host loader write port into memory
//  cur_addr              {hi, address} of the last committed access
//  bus_err, wp_fault     sticky error flags
module as1802_bus_responder
  import as1802_bus_pkg::*;
#(
  parameter int unsigned MEM_AW   = 9,
  parameter logic [7:0]  RESET_HI = 8'hFF,
  parameter logic [15:0] WP_LIMIT = 16'h0100
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          address,
  input  logic                tpa,
  input  logic                mrd,
  input  logic                mwr,
  input  logic [2:0]          n,
  input  logic [7:0]          wr_data,
  output logic [7:0]          rd_data,
  input  logic [IO_BUS_W-1:0] io_in,
  output logic [IO_BUS_W-1:0] io_out,
  output logic [IO_PORTS-1:0] io_out_strb,
  input  logic                ld_we,
  input  logic [15:0]         ld_addr,
  input  logic [7:0]          ld_data,
  output logic [15:0]         cur_addr,
  output logic                bus_err,
  output logic                wp_fault
);

`ifdef AS1802_BUS_WP_EN
  localparam bit WP_EN = 1'b1;
`else
  localparam bit WP_EN = 1'b0;
`endif

  bus_state_t state_reg, state_next;
  logic [7:0]  hi_reg;
  logic [15:0] cur_addr_reg;
  logic        bus_err_reg;
  logic        mwr_low_reg;

  logic [15:0] full_addr;
  logic        rd_en;
  logic        wr_strobe;
  logic        mem_wr_req;
  logic        io_wr;
  logic        wp_drop;
  logic        mem_we;
  logic        cur_upd;
  logic        hi_wr_err;
  logic        err_now;
  logic [7:0]  mem_rdata;
  logic [7:0]  rd_sel [IO_PORTS+1];

  logic        unused_ld_bits;
  assign unused_ld_bits = ^ld_addr[15:MEM_AW];

  assign full_addr = {hi_reg, address};
  assign rd_en     = !mrd && mwr && !tpa;
  // A write during reset must not touch memory: the rest of the block is
  // held in reset and the memory itself has no reset.
  assign wr_strobe  = !mrd && !mwr && rst_n;
  assign mem_wr_req = wr_strobe && (n == 3'd0);
  assign io_wr      = wr_strobe && (n != 3'd0);
  assign wp_drop    = WP_EN && mem_wr_req && (full_addr < WP_LIMIT);
  assign mem_we     = mem_wr_req && !wp_drop;

  as1802_bus_mem #(
    .AW(MEM_AW)
  ) u_mem (
    .clk      (clk),
    .rd_addr  (full_addr[MEM_AW-1:0]),
    .rd_data  (mem_rdata),
    .cpu_we   (mem_we),
    .cpu_addr (full_addr[MEM_AW-1:0]),
    .cpu_data (wr_data),
    .ld_we    (ld_we),
    .ld_addr  (ld_addr[MEM_AW-1:0]),
    .ld_data  (ld_data)
  );

  // Read source table indexed directly by n: entry 0 is memory.
  assign rd_sel[0] = mem_rdata;

  for (genvar gi = 1; gi <= IO_PORTS; gi++) begin : g_port
    logic [7:0] port_reg;
    logic       strb_reg;

    assign rd_sel[gi] = io_in[PORT_W*gi-1 -: PORT_W];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        port_reg <= 8'h00;
        strb_reg <= 1'b0;
      end else begin
        strb_reg <= io_wr && (n == 3'(gi));
        if (io_wr && (n == 3'(gi))) port_reg <= wr_data;
      end
    end

    assign io_out[PORT_W*gi-1 -: PORT_W] = port_reg;
    assign io_out_strb[gi-1]             = strb_reg;
  end

  always_comb begin
    rd_data = 8'h00;
    if (rd_en) rd_data = rd_sel[n];
  end

  // Bus-cycle tracking. Only used to time cur_addr updates for reads and to
  // catch a write strobe arriving while the high byte is still on the bus.
  always_comb begin
    state_next = state_reg;
    cur_upd    = 1'b0;
    hi_wr_err  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!mrd) state_next = tpa ? HI : LO;
      end
      HI: begin
        hi_wr_err = !mwr;
        if (mrd)       state_next = IDLE;
        else if (!tpa) state_next = LO;
      end
      LO: begin
        if (mrd) begin
          state_next = IDLE;
          cur_upd    = 1'b1;
        end else if (!mwr) begin
          state_next = WR;
        end
      end
      WR: begin
        if (mrd) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign err_now = (!mwr && mrd) || (tpa && mrd) || hi_wr_err || (!mwr && mwr_low_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      hi_reg       <= RESET_HI;
      cur_addr_reg <= 16'h0000;
      bus_err_reg  <= 1'b0;
      mwr_low_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      mwr_low_reg <= !mwr;
      if (tpa && !mrd) hi_reg <= address;
      if (mem_we || cur_upd) cur_addr_reg <= full_addr;
      if (err_now) bus_err_reg <= 1'b1;
    end
  end

  assign cur_addr = cur_addr_reg;
  assign bus_err  = bus_err_reg;

`ifdef AS1802_BUS_WP_EN
  logic wp_fault_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       wp_fault_reg <= 1'b0;
    else if (wp_drop) wp_fault_reg <= 1'b1;
  end
  assign wp_fault = wp_fault_reg;
`else
  assign wp_fault = 1'b0;
`endif

endmodule
